// File: rtl/pipeline_pkg.sv
// Shared encodings for the ARM pipeline control and hazard unit.
package pipeline_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_EOR = 5'b00001;
   localparam logic [4:0] ALU_SUB = 5'b00010;
   localparam logic [4:0] ALU_RSB = 5'b00011;
   localparam logic [4:0] ALU_ADD = 5'b00100;
   localparam logic [4:0] ALU_ADC = 5'b00101;
   localparam logic [4:0] ALU_SBC = 5'b00110;
   localparam logic [4:0] ALU_RSC = 5'b00111;
   localparam logic [4:0] ALU_ORR = 5'b01100;
   localparam logic [4:0] ALU_MOV = 5'b01101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef struct packed {
      logic       reg_w;
      logic       mem_w;
      logic       mem_to_reg;
      logic       pcs;
      logic       branch;
      logic       alu_src;
      logic [4:0] alu_ctrl;
      logic [1:0] flag_w;
      logic [3:0] cond;
   } ctrl_t;

   // Arithmetic commands (and compares) also produce carry/overflow.
   function automatic logic updates_cv(input logic [3:0] cmd);
      case (cmd)
         4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1010, 4'b1011: updates_cv = 1'b1;
         default:                            updates_cv = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and condition evaluation for the instruction in Execute.
module cond_unit
   import pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] CondE,
   input  logic [1:0] FlagWE,
   input  logic [3:0] ALUFlagsE,
   output logic       CondExE
);

   logic [3:0] flags;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      case (CondE)
         COND_EQ: CondExE = z;
         COND_NE: CondExE = ~z;
         COND_CS: CondExE = c;
         COND_CC: CondExE = ~c;
         COND_MI: CondExE = n;
         COND_PL: CondExE = ~n;
         COND_VS: CondExE = v;
         COND_VC: CondExE = ~v;
         COND_HI: CondExE = c & ~z;
         COND_LS: CondExE = ~c | z;
         COND_GE: CondExE = (n == v);
         COND_LT: CondExE = (n != v);
         COND_GT: CondExE = ~z & (n == v);
         COND_LE: CondExE = z | (n != v);
         COND_AL: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (CondExE && FlagWE[1]) flags[3:2] <= ALUFlagsE[3:2];
         if (CondExE && FlagWE[0]) flags[1:0] <= ALUFlagsE[1:0];
      end
   end

endmodule

// File: rtl/pipeline_control.sv
// Decode, D/E/M/W control pipeline, forwarding and hazard logic for the
// 5-stage ARM datapath.
module pipeline_control
   import pipeline_pkg::*;
#(
   parameter int ALUCONTROL_WIDTH = 5
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 InstrD,
   input  logic [3:0]                  ALUFlagsE,
   input  logic                        Match_1E_M,
   input  logic                        Match_1E_W,
   input  logic                        Match_2E_M,
   input  logic                        Match_2E_W,
   input  logic                        Match_12D_E,
   output logic [1:0]                  RegSrcD,
   output logic [1:0]                  ImmSrcD,
   output logic                        ALUSrcE,
   output logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
   output logic                        BranchTakenE,
   output logic                        MemWriteM,
   output logic                        MemtoRegW,
   output logic                        PCSrcW,
   output logic                        RegWriteW,
   output logic [1:0]                  ForwardAE,
   output logic [1:0]                  ForwardBE,
   output logic                        StallF,
   output logic                        StallD,
   output logic                        FlushD
);

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cond;
   logic       unused_bits;

   ctrl_t ctrl_d, ctrl_e;
   logic  cond_ex;
   logic  reg_w_ge, mem_w_ge, pcs_ge;
   logic  reg_w_m, mem_w_m, mem_to_reg_m, pcs_m;
   logic  reg_w_w, mem_to_reg_w, pcs_w;
   logic  ldr_stall, pc_wr_pend, flush_e;

   assign op          = InstrD[27:26];
   assign funct       = InstrD[25:20];
   assign rd          = InstrD[15:12];
   assign cond        = InstrD[31:28];
   assign unused_bits = ^{InstrD[19:16], InstrD[11:0]};

   always_comb begin
      ctrl_d    = '0;
      RegSrcD   = 2'b00;
      ImmSrcD   = 2'b00;
      case (op)
         OP_DP: begin
            ctrl_d.reg_w    = (funct[4:3] != 2'b10);
            ctrl_d.alu_src  = funct[5];
            ctrl_d.alu_ctrl = {1'b0, funct[4:1]};
            ctrl_d.flag_w   = {funct[0], funct[0] & updates_cv(funct[4:1])};
            ctrl_d.cond     = cond;
         end
         OP_MEM: begin
            ctrl_d.reg_w      = funct[0];
            ctrl_d.mem_w      = ~funct[0];
            ctrl_d.mem_to_reg = funct[0];
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.alu_ctrl   = InstrD[23] ? ALU_ADD : ALU_SUB;
            ctrl_d.cond       = cond;
            ImmSrcD           = 2'b01;
            RegSrcD           = {~funct[0], 1'b0};
         end
         OP_BR: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.alu_src  = 1'b1;
            ctrl_d.alu_ctrl = ALU_ADD;
            ctrl_d.cond     = cond;
            ImmSrcD         = 2'b10;
            RegSrcD         = 2'b01;
         end
         default: ;
      endcase
      ctrl_d.pcs = ((rd == 4'hF) & ctrl_d.reg_w) | ctrl_d.branch;
   end

   cond_unit u_cond_unit (
      .clk       (clk),
      .reset     (reset),
      .CondE     (ctrl_e.cond),
      .FlagWE    (ctrl_e.flag_w),
      .ALUFlagsE (ALUFlagsE),
      .CondExE   (cond_ex)
   );

   assign reg_w_ge     = ctrl_e.reg_w & cond_ex;
   assign mem_w_ge     = ctrl_e.mem_w & cond_ex;
   assign pcs_ge       = ctrl_e.pcs & cond_ex;
   assign BranchTakenE = ctrl_e.branch & cond_ex;

   assign ldr_stall  = Match_12D_E & ctrl_e.mem_to_reg;
   assign pc_wr_pend = ctrl_d.pcs | pcs_ge | pcs_m;
   // A taken branch and a load-use stall both bubble E; the bubble wins over holding.
   assign flush_e    = ldr_stall | BranchTakenE;

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e       <= '0;
         reg_w_m      <= 1'b0;
         mem_w_m      <= 1'b0;
         mem_to_reg_m <= 1'b0;
         pcs_m        <= 1'b0;
         reg_w_w      <= 1'b0;
         mem_to_reg_w <= 1'b0;
         pcs_w        <= 1'b0;
      end else begin
         ctrl_e       <= flush_e ? '0 : ctrl_d;
         reg_w_m      <= reg_w_ge;
         mem_w_m      <= mem_w_ge;
         mem_to_reg_m <= ctrl_e.mem_to_reg;
         pcs_m        <= pcs_ge;
         reg_w_w      <= reg_w_m;
         mem_to_reg_w <= mem_to_reg_m;
         pcs_w        <= pcs_m;
      end
   end

   always_comb begin
      if (Match_1E_M && reg_w_m)      ForwardAE = FWD_M;
      else if (Match_1E_W && reg_w_w) ForwardAE = FWD_W;
      else                            ForwardAE = FWD_RF;
      if (Match_2E_M && reg_w_m)      ForwardBE = FWD_M;
      else if (Match_2E_W && reg_w_w) ForwardBE = FWD_W;
      else                            ForwardBE = FWD_RF;
   end

   assign ALUSrcE     = ctrl_e.alu_src;
   assign ALUControlE = ALUCONTROL_WIDTH'(ctrl_e.alu_ctrl);
   assign MemWriteM   = mem_w_m;
   assign MemtoRegW   = mem_to_reg_w;
   assign PCSrcW      = pcs_w;
   assign RegWriteW   = reg_w_w;
   assign StallF      = ldr_stall | pc_wr_pend;
   assign StallD      = ldr_stall;
   assign FlushD      = pc_wr_pend | pcs_w | BranchTakenE;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: stimulus schedules expected outputs per
// cycle into a scoreboard, a negedge monitor compares them against the DUT.
module tb_pipeline_control;

   logic        clk;
   logic        reset;
   logic [31:0] InstrD;
   logic [3:0]  ALUFlagsE;
   logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
   logic [1:0]  RegSrcD, ImmSrcD;
   logic        ALUSrcE;
   logic [4:0]  ALUControlE;
   logic        BranchTakenE, MemWriteM, MemtoRegW, PCSrcW, RegWriteW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, FlushD;

   pipeline_control #(.ALUCONTROL_WIDTH(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .InstrD       (InstrD),
      .ALUFlagsE    (ALUFlagsE),
      .Match_1E_M   (Match_1E_M),
      .Match_1E_W   (Match_1E_W),
      .Match_2E_M   (Match_2E_M),
      .Match_2E_W   (Match_2E_W),
      .Match_12D_E  (Match_12D_E),
      .RegSrcD      (RegSrcD),
      .ImmSrcD      (ImmSrcD),
      .ALUSrcE      (ALUSrcE),
      .ALUControlE  (ALUControlE),
      .BranchTakenE (BranchTakenE),
      .MemWriteM    (MemWriteM),
      .MemtoRegW    (MemtoRegW),
      .PCSrcW       (PCSrcW),
      .RegWriteW    (RegWriteW),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD)
   );

   localparam int F_REGSRC = 0, F_IMMSRC = 1, F_ALUSRC = 2, F_ALUCTL = 3,
                  F_BRT = 4, F_MEMW = 5, F_M2R = 6, F_PCSRC = 7, F_REGW = 8,
                  F_FWDA = 9, F_FWDB = 10, F_STALLF = 11, F_STALLD = 12, F_FLUSHD = 13;

   localparam logic [4:0] M1M = 5'b10000, M1W = 5'b01000, M2M = 5'b00100,
                          M2W = 5'b00010, M12D = 5'b00001;

   localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, NV = 4'b1111, AL = 4'b1110;
   localparam logic [3:0] C_AND = 4'b0000, C_SUB = 4'b0010, C_ADD = 4'b0100,
                          C_CMP = 4'b1010, C_ORR = 4'b1100, C_MOV = 4'b1101;
   localparam logic [31:0] NOP = 32'h0C00_0000;

   typedef struct {
      int         cyc;
      int         fld;
      logic [4:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                                      input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] src2);
      return {c, 2'b00, i, cmd, s, rn, rd, src2};
   endfunction

   function automatic logic [31:0] mem(input logic u, input logic l, input logic [3:0] rn,
                                       input logic [3:0] rd, input logic [11:0] imm);
      return {AL, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, l, rn, rd, imm};
   endfunction

   function automatic logic [31:0] br(input logic [3:0] c);
      return {c, 2'b10, 2'b10, 24'h000010};
   endfunction

   function automatic logic [4:0] actual(input int f);
      case (f)
         F_REGSRC: return {3'b0, RegSrcD};
         F_IMMSRC: return {3'b0, ImmSrcD};
         F_ALUSRC: return {4'b0, ALUSrcE};
         F_ALUCTL: return ALUControlE;
         F_BRT:    return {4'b0, BranchTakenE};
         F_MEMW:   return {4'b0, MemWriteM};
         F_M2R:    return {4'b0, MemtoRegW};
         F_PCSRC:  return {4'b0, PCSrcW};
         F_REGW:   return {4'b0, RegWriteW};
         F_FWDA:   return {3'b0, ForwardAE};
         F_FWDB:   return {3'b0, ForwardBE};
         F_STALLF: return {4'b0, StallF};
         F_STALLD: return {4'b0, StallD};
         default:  return {4'b0, FlushD};
      endcase
   endfunction

   task automatic step(input logic [31:0] instr, input logic [4:0] m = 5'b0,
                       input logic [3:0] fl = 4'b0);
      @(posedge clk);
      #1;
      InstrD    = instr;
      ALUFlagsE = fl;
      {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = m;
   endtask

   task automatic chk(input int off, input int f, input logic [4:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc + off;
      e.fld  = f;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            n_checks++;
            if (actual(sb[i].fld) === sb[i].exp) n_pass++;
            else $display("FAIL %s (cycle %0d): actual %0h required %0h",
                          sb[i].name, cyc, actual(sb[i].fld), sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      reset = 1'b1;
      InstrD = NOP;
      ALUFlagsE = 4'b0;
      {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'b0;

      // reset state
      step(NOP);
      step(NOP, 5'b11111);
      n_checks++;
      if (MemWriteM === 1'b0) n_pass++;
      else $display("FAIL imm_rst_memw: actual %0h required 0", MemWriteM);
      n_checks++;
      if (RegWriteW === 1'b0) n_pass++;
      else $display("FAIL imm_rst_regw: actual %0h required 0", RegWriteW);
      n_checks++;
      if (PCSrcW === 1'b0) n_pass++;
      else $display("FAIL imm_rst_pcsrc: actual %0h required 0", PCSrcW);
      n_checks++;
      if (StallD === 1'b0) n_pass++;
      else $display("FAIL imm_rst_stalld: actual %0h required 0", StallD);
      chk(0, F_ALUSRC, 0, "rst_alusrc");   chk(0, F_ALUCTL, 0, "rst_aluctl");
      chk(0, F_MEMW, 0, "rst_memw");       chk(0, F_M2R, 0, "rst_mem2reg");
      chk(0, F_PCSRC, 0, "rst_pcsrc");     chk(0, F_REGW, 0, "rst_regw");
      chk(0, F_FWDA, 0, "rst_fwda");       chk(0, F_STALLD, 0, "rst_stalld");
      chk(0, F_STALLF, 0, "rst_stallf");   chk(0, F_FLUSHD, 0, "rst_flushd");
      reset = 1'b0;
      step(NOP);

      // ADD R1 then SUB using R1: forward from M
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      chk(0, F_REGSRC, 0, "add_regsrc");   chk(0, F_IMMSRC, 0, "add_immsrc");
      chk(1, F_ALUCTL, 5'b00100, "add_aluctl"); chk(1, F_ALUSRC, 0, "add_alusrc");
      step(dp(AL, 0, C_SUB, 0, 1, 4, 12'd5), M12D);
      chk(0, F_STALLD, 0, "dp_no_ldstall");
      step(NOP, M1M);
      chk(0, F_FWDA, 2'b10, "fwd_m");      chk(0, F_ALUCTL, 5'b00010, "sub_aluctl");
      step(NOP); step(NOP);

      // one unrelated instruction between: forward from W
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      step(dp(AL, 0, C_ORR, 0, 7, 6, 12'd8));
      step(dp(AL, 0, C_SUB, 0, 1, 4, 12'd5));
      step(NOP, M1W);
      chk(0, F_FWDA, 2'b01, "fwd_w");
      step(NOP); step(NOP);

      // M has priority over W on both operands
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      step(dp(AL, 0, C_SUB, 0, 1, 4, 12'd1));
      step(NOP, M1M | M1W | M2M | M2W);
      chk(0, F_FWDA, 2'b10, "fwd_a_prio"); chk(0, F_FWDB, 2'b10, "fwd_b_prio");
      step(NOP, M2W);
      chk(0, F_FWDB, 2'b01, "fwd_b_w");
      step(NOP); step(NOP);

      // LDR R1,[R2] then ADD R3,R1,R4: one-cycle load-use stall
      step(mem(1, 1, 2, 1, 12'd0));
      chk(0, F_IMMSRC, 2'b01, "ldr_immsrc"); chk(0, F_REGSRC, 0, "ldr_regsrc");
      chk(1, F_ALUSRC, 1, "ldr_alusrc");     chk(1, F_ALUCTL, 5'b00100, "ldr_aluctl");
      step(dp(AL, 0, C_ADD, 0, 1, 3, 12'd4), M12D);
      chk(0, F_STALLF, 1, "ldu_stallf");     chk(0, F_STALLD, 1, "ldu_stalld");
      chk(0, F_FLUSHD, 0, "ldu_flushd");
      step(dp(AL, 0, C_ADD, 0, 1, 3, 12'd4));
      chk(0, F_STALLF, 0, "ldu_stallf_end"); chk(0, F_STALLD, 0, "ldu_stalld_end");
      chk(0, F_ALUCTL, 0, "ldu_bubble");
      step(NOP, M1W);
      chk(0, F_FWDA, 2'b01, "ldu_fwd_w");    chk(0, F_M2R, 1, "ldr_mem2reg");
      chk(0, F_REGW, 1, "ldr_regw");         chk(0, F_ALUCTL, 5'b00100, "ldu_add_in_e");
      step(NOP); step(NOP);

      // STR with U=0; a store in M is not a forwarding source
      step(mem(0, 0, 2, 1, 12'd4));
      chk(0, F_REGSRC, 2'b10, "str_regsrc"); chk(0, F_IMMSRC, 2'b01, "str_immsrc");
      chk(1, F_ALUCTL, 5'b00010, "str_aluctl"); chk(2, F_MEMW, 1, "str_memw");
      step(dp(AL, 0, C_SUB, 0, 1, 5, 12'd6));
      step(NOP, M1M);
      chk(0, F_FWDA, 2'b00, "fwd_str_m");
      step(NOP);
      chk(0, F_MEMW, 0, "str_memw_end");     chk(0, F_REGW, 0, "str_regw");
      step(NOP);

      // SUBS R0,R0,R0 then BEQ: taken
      step(dp(AL, 0, C_SUB, 1, 0, 0, 12'd0));
      step(br(EQ), 5'b0, 4'b0110);
      chk(0, F_REGSRC, 2'b01, "b_regsrc");   chk(0, F_IMMSRC, 2'b10, "b_immsrc");
      chk(0, F_STALLF, 1, "b_d_stallf");     chk(0, F_FLUSHD, 1, "b_d_flushd");
      step(dp(AL, 1, C_ADD, 0, 9, 9, 12'd1));
      chk(0, F_BRT, 1, "beq_taken");         chk(0, F_FLUSHD, 1, "beq_flushd");
      chk(0, F_ALUSRC, 1, "b_alusrc");       chk(0, F_ALUCTL, 5'b00100, "b_aluctl");
      chk(1, F_ALUCTL, 0, "beq_flushe_ctl"); chk(1, F_ALUSRC, 0, "beq_flushe_src");
      chk(2, F_PCSRC, 1, "beq_pcsrcw");      chk(3, F_REGW, 0, "beq_flushe_regw");
      step(NOP); step(NOP); step(NOP); step(NOP);

      // BNE in the same position: not taken
      step(dp(AL, 0, C_SUB, 1, 0, 0, 12'd0));
      step(br(NE), 5'b0, 4'b0110);
      step(NOP);
      chk(0, F_BRT, 0, "bne_not_taken");     chk(0, F_FLUSHD, 0, "bne_flushd");
      chk(1, F_STALLF, 0, "bne_m_stallf");   chk(2, F_PCSRC, 0, "bne_pcsrcw");
      step(NOP); step(NOP); step(NOP);

      // conditional execution and partial flag updates
      step(dp(AL, 1, C_CMP, 1, 0, 0, 12'd1));
      step(dp(EQ, 0, C_ADD, 0, 2, 1, 12'd3), 5'b0, 4'b0011);
      chk(3, F_REGW, 0, "addeq_z0");
      step(dp(NE, 0, C_ADD, 0, 2, 1, 12'd3));
      chk(3, F_REGW, 1, "addne_z0");
      step(dp(AL, 0, C_AND, 1, 6, 5, 12'd7));
      step(dp(CS, 0, C_ADD, 0, 2, 8, 12'd3), 5'b0, 4'b1100);
      chk(3, F_REGW, 1, "ands_keeps_c");
      step(dp(EQ, 0, C_ADD, 0, 2, 8, 12'd3));
      chk(3, F_REGW, 1, "ands_sets_z");
      step(dp(NV, 0, C_SUB, 1, 2, 8, 12'd3));
      chk(3, F_REGW, 0, "nv_no_write");
      step(dp(EQ, 0, C_ADD, 0, 2, 8, 12'd3), 5'b0, 4'b0000);
      chk(3, F_REGW, 1, "nv_no_flagw");
      step(NOP); step(NOP); step(NOP); step(NOP);

      // MOV PC,R2
      step(dp(AL, 0, C_MOV, 0, 0, 15, 12'd2));
      chk(0, F_STALLF, 1, "movpc_d_stallf"); chk(0, F_FLUSHD, 1, "movpc_d_flushd");
      chk(1, F_STALLF, 1, "movpc_e_stallf"); chk(2, F_STALLF, 1, "movpc_m_stallf");
      chk(3, F_PCSRC, 1, "movpc_pcsrcw");    chk(3, F_FLUSHD, 1, "movpc_w_flushd");
      chk(3, F_STALLF, 0, "movpc_w_stallf"); chk(3, F_REGW, 1, "movpc_regw");
      step(NOP); step(NOP); step(NOP); step(NOP);

      // reset mid-stream discards in-flight control
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      step(mem(0, 0, 2, 1, 12'd4));
      step(dp(AL, 0, C_ADD, 0, 2, 1, 12'd3));
      reset = 1'b1;
      chk(0, F_ALUCTL, 5'b00010, "rst_sync_hold");
      step(NOP);
      reset = 1'b0;
      n_checks++;
      if (MemtoRegW === 1'b0) n_pass++;
      else $display("FAIL imm_midrst_mem2reg: actual %0h required 0", MemtoRegW);
      n_checks++;
      if (PCSrcW === 1'b0) n_pass++;
      else $display("FAIL imm_midrst_pcsrc: actual %0h required 0", PCSrcW);
      chk(0, F_MEMW, 0, "midrst_memw");      chk(0, F_REGW, 0, "midrst_regw");
      chk(0, F_ALUCTL, 0, "midrst_aluctl");  chk(0, F_ALUSRC, 0, "midrst_alusrc");
      step(NOP); step(NOP);

      @(posedge clk);
      #1;
      foreach (sb[i]) begin
         n_checks++;
         $display("FAIL %s: never sampled, required %0h", sb[i].name, sb[i].exp);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      if (n_pass == n_checks) $display("PASS");
      else $display("FAIL: %0d checks failed", n_checks - n_pass);
      $finish;
   end

endmodule
